// File: rtl/stall_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: stall encodings, ERET code, FSM states.
package stall_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned XLEN    = 32;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [XLEN-1:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  // Deepest requester wins: a stall freezes its own stage and everything upstream.
  function automatic logic [STALL_W-1:0] stall_encode(input logic r_if, input logic r_id,
                                                      input logic r_ex, input logic r_mem);
    if (r_mem)     return STALL_MEM;
    else if (r_ex) return STALL_EX;
    else if (r_id) return STALL_ID;
    else if (r_if) return STALL_IF;
    else           return STALL_NONE;
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Stall-request / redirect bundle between the pipeline stages and stall_ctrl.
interface stall_ctrl_if;
  import stall_ctrl_pkg::*;

  logic               stallreq_if;
  logic               stallreq_id;
  logic               stallreq_ex;
  logic               stallreq_mem;
  logic [XLEN-1:0]    excepttype_i;
  logic [XLEN-1:0]    cp0_epc_i;
  logic               wdt_clr;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [XLEN-1:0]    new_pc;
  logic               stall_timeout;
  logic [XLEN-1:0]    stall_cnt;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excepttype_i, cp0_epc_i, wdt_clr,
    input  stall, flush, new_pc, stall_timeout, stall_cnt
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excepttype_i, cp0_epc_i, wdt_clr,
    output stall, flush, new_pc, stall_timeout, stall_cnt
  );

endinterface

// File: rtl/stall_wdt.sv
// Stall watchdog: total stalled-cycle counter plus a sticky flag for long stall runs.
module stall_wdt #(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_any,
  input  logic        flush,
  input  logic        wdt_clr,
  output logic        stall_timeout,
  output logic [31:0] stall_cnt
);

  localparam int unsigned RUN_W = $clog2(STALL_TIMEOUT + 1);

  logic [RUN_W-1:0] run_q, run_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             set_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= '0;
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  // Set fires on the edge the run reaches the limit and takes priority over clear.
  always_comb begin
    run_d = run_q;
    if (!stall_any || flush)
      run_d = '0;
    else if (run_q != RUN_W'(STALL_TIMEOUT))
      run_d = run_q + RUN_W'(1);

    set_c = stall_any && !flush && (run_q == RUN_W'(STALL_TIMEOUT - 1));

    tmo_d = tmo_q;
    if (set_c)
      tmo_d = 1'b1;
    else if (wdt_clr)
      tmo_d = 1'b0;

    cnt_d = stall_any ? cnt_q + 32'd1 : cnt_q;
  end

  assign stall_timeout = tmo_q;
  assign stall_cnt     = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: stall priority, exception redirect and a
// post-flush blanking window that masks stale front-end requests.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned     STALL_TIMEOUT = 1024,
  parameter logic [XLEN-1:0] EXC_VECTOR    = 32'hBFC0_0380,
  parameter int unsigned     BLANK_CYCLES  = 2
) (
  input  logic         clk,
  input  logic         rst,
  stall_ctrl_if.slave  bus
);

  localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [BLANK_W-1:0]   blank_q, blank_d;
  logic [STALL_W-1:0]   stall_c;
  logic                 flush_c;
  logic [XLEN-1:0]      new_pc_c;
  logic                 exc_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
    end
  end

  // Exceptions are only taken out of reset; during reset stall still follows requests.
  always_comb begin
    state_d  = state_q;
    blank_d  = blank_q;
    stall_c  = STALL_NONE;
    flush_c  = 1'b0;
    new_pc_c = '0;
    exc_c    = rst && (bus.excepttype_i != '0);

    case (state_q)
      ST_IDLE: begin
        if (exc_c) begin
          flush_c  = 1'b1;
          new_pc_c = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
          state_d  = ST_BLANK;
          blank_d  = BLANK_W'(BLANK_CYCLES - 1);
        end else begin
          stall_c = stall_encode(bus.stallreq_if, bus.stallreq_id,
                                 bus.stallreq_ex, bus.stallreq_mem);
        end
      end
      ST_BLANK: begin
        stall_c = stall_encode(1'b0, 1'b0, bus.stallreq_ex, bus.stallreq_mem);
        if (blank_q == '0)
          state_d = ST_IDLE;
        else
          blank_d = blank_q - BLANK_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        blank_d = '0;
      end
    endcase
  end

  assign bus.stall  = stall_c;
  assign bus.flush  = flush_c;
  assign bus.new_pc = new_pc_c;

  stall_wdt #(
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_wdt (
    .clk           (clk),
    .rst           (rst),
    .stall_any     (stall_c != STALL_NONE),
    .flush         (flush_c),
    .wdt_clr       (bus.wdt_clr),
    .stall_timeout (bus.stall_timeout),
    .stall_cnt     (bus.stall_cnt)
  );

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: priority, flush/blanking, watchdog, counter wrap, reset.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  stall_ctrl_if bus();

  stall_ctrl #(
    .STALL_TIMEOUT (1024),
    .EXC_VECTOR    (32'hBFC0_0380),
    .BLANK_CYCLES  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one input vector just after the falling edge, then let combinational logic settle.
  task automatic drive(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem,
                       input logic [31:0] exc, input logic [31:0] epc, input logic clr);
    @(negedge clk);
    bus.stallreq_if  = r_if;
    bus.stallreq_id  = r_id;
    bus.stallreq_ex  = r_ex;
    bus.stallreq_mem = r_mem;
    bus.excepttype_i = exc;
    bus.cp0_epc_i    = epc;
    bus.wdt_clr      = clr;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 1, 0, 32'h1, 32'h0, 0);
    chk("rst_stall", 32'(bus.stall), 32'h0f);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_newpc", bus.new_pc, 32'h0);
    @(posedge clk); #1;
    chk("rst_cnt", bus.stall_cnt, 32'h0);
    chk("rst_tmo", 32'(bus.stall_timeout), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    rst = 1'b1;

    drive(0, 1, 0, 1, 32'h0, 32'h0, 0);
    chk("prio_id_mem", 32'(bus.stall), 32'h1f);
    drive(0, 1, 0, 0, 32'h0, 32'h0, 0);
    chk("prio_id", 32'(bus.stall), 32'h07);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("prio_if", 32'(bus.stall), 32'h03);
    drive(0, 0, 1, 0, 32'h0, 32'h0, 0);
    chk("prio_ex", 32'(bus.stall), 32'h0f);

    // General exception, then two blanked cycles with an IF request pending
    drive(1, 0, 0, 0, 32'h1, 32'h0, 0);
    chk("exc_flush", 32'(bus.flush), 32'h1);
    chk("exc_newpc", bus.new_pc, 32'hBFC0_0380);
    chk("exc_stall", 32'(bus.stall), 32'h0);
    chk("cnt_after4", bus.stall_cnt, 32'd4);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("blank1_stall", 32'(bus.stall), 32'h0);
    chk("blank1_flush", 32'(bus.flush), 32'h0);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("blank2_stall", 32'(bus.stall), 32'h0);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("unblank_stall", 32'(bus.stall), 32'h03);

    // ERET redirect; exception during blank is ignored, EX still honoured, ID masked
    drive(0, 0, 0, 0, 32'he, 32'h8000_1234, 0);
    chk("eret_flush", 32'(bus.flush), 32'h1);
    chk("eret_newpc", bus.new_pc, 32'h8000_1234);
    chk("cnt_after5", bus.stall_cnt, 32'd5);
    drive(0, 1, 1, 0, 32'h1, 32'h8000_1234, 0);
    chk("blank_exc_flush", 32'(bus.flush), 32'h0);
    chk("blank_exc_newpc", bus.new_pc, 32'h0);
    chk("blank_ex_stall", 32'(bus.stall), 32'h0f);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("eret_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("cnt_after6", bus.stall_cnt, 32'd6);

    // Asynchronous reset in the middle of BLANK
    drive(0, 0, 0, 0, 32'h1, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("blank_state", 32'(dut.state_q), 32'(ST_BLANK));
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("arst_blank", 32'(dut.blank_q), 32'h0);
    chk("arst_cnt", bus.stall_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.excepttype_i = 32'h1;
    #1;
    chk("post_rst_flush", 32'(bus.flush), 32'h1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);

    // Watchdog trips exactly on the 1024th consecutive stalled edge
    drive(0, 0, 1, 0, 32'h0, 32'h0, 0);
    repeat (1023) @(posedge clk);
    #1;
    chk("wdt_1023", 32'(bus.stall_timeout), 32'h0);
    chk("cnt_1023", bus.stall_cnt, 32'd1023);
    @(posedge clk); #1;
    chk("wdt_1024", 32'(bus.stall_timeout), 32'h1);
    chk("cnt_1024", bus.stall_cnt, 32'd1024);
    chk("wdt_no_stall_effect", 32'(bus.stall), 32'h0f);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1);
    chk("wdt_sticky", 32'(bus.stall_timeout), 32'h1);
    @(posedge clk); #1;
    chk("wdt_clr", 32'(bus.stall_timeout), 32'h0);

    // Set and clear in the same cycle: set wins
    drive(0, 0, 1, 0, 32'h0, 32'h0, 0);
    repeat (1023) @(posedge clk);
    #1;
    chk("wdt2_1023", 32'(bus.stall_timeout), 32'h0);
    drive(0, 0, 1, 0, 32'h0, 32'h0, 1);
    @(posedge clk); #1;
    chk("wdt_set_wins", 32'(bus.stall_timeout), 32'h1);
    chk("cnt_2048", bus.stall_cnt, 32'd2048);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    chk("wdt_hold", 32'(bus.stall_timeout), 32'h1);

    // stall_cnt wraps to zero
    @(negedge clk);
    dut.u_wdt.cnt_q = 32'hFFFF_FFFF;
    bus.stallreq_ex = 1'b1;
    #1;
    chk("cnt_preload", bus.stall_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("cnt_wrap", bus.stall_cnt, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter STALL_TIMEOUT, default 1024, meaning consecutive nonzero-stall cycles before the watchdog trips.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, meaning the general exception entry PC.
REQ-003 SHALL have parameter BLANK_CYCLES, default 2, meaning cycles after a flush during which stale requests are masked.
REQ-004 SHALL use one clock, clk; reset is rst, asynchronous, active-low (0 = reset).
REQ-005 SHALL provide the following ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- stallreq_if  in  1  IF stage stall request
- stallreq_id  in  1  ID stage stall request (load-use)
- stallreq_ex  in  1  EX stage stall request (multi-cycle ALU)
- stallreq_mem  in  1  MEM stage stall request
- excepttype_i  in  32  MEM-stage exception code; 0 = none
- cp0_epc_i  in  32  current EPC
- wdt_clr  in  1  clears sticky timeout
- stall  out  6  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB hold
- flush  out  1  pipeline flush pulse
- new_pc  out  32  redirect target, valid with flush
- stall_timeout  out  1  sticky watchdog flag
- stall_cnt  out  32  total stalled cycles

Function
REQ-006 stall SHALL be combinational, priority by deepest requester: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, if -> 6'b000011, none -> 6'b000000.
REQ-007 The FSM SHALL have the states IDLE and BLANK.
REQ-008 In IDLE with excepttype_i != 0: flush SHALL be 1 combinationally, stall SHALL be 6'b000000, and the next state SHALL be BLANK with blank counter = BLANK_CYCLES-1.
REQ-009 new_pc SHALL equal cp0_epc_i when excepttype_i == 32'h0000000e (ERET) and EXC_VECTOR for any other nonzero code; it SHALL be 0 when flush = 0.
REQ-010 In BLANK: excepttype_i SHALL be ignored (flush = 0), stallreq_if and stallreq_id SHALL be masked, and stallreq_ex and stallreq_mem SHALL be honoured.
REQ-011 BLANK SHALL decrement its counter each cycle and return to IDLE on the cycle the counter reads 0; BLANK_CYCLES = 1 gives exactly one BLANK cycle.
REQ-012 stall_cnt SHALL increment by 1 on every clk edge where stall != 0, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-013 A run counter SHALL count consecutive cycles with stall != 0 and SHALL clear on any cycle with stall == 0 or flush == 1; it SHALL saturate at STALL_TIMEOUT.
REQ-014 stall_timeout SHALL set on the edge where the run counter reaches STALL_TIMEOUT and SHALL stay set until wdt_clr = 1.
REQ-015 When wdt_clr and the set condition occur in the same cycle, set SHALL win.
REQ-016 The watchdog SHALL NOT alter stall; it only reports.

Reset
REQ-017 While rst = 0: state = IDLE, blank counter = 0, run counter = 0, stall_cnt = 0, stall_timeout = 0.
REQ-018 During reset, combinational outputs SHALL evaluate as in IDLE: flush = 0, new_pc = 0, and stall SHALL follow the requests.
REQ-019 Reset asserted mid-BLANK SHALL return to IDLE immediately, asynchronously.

Structure
REQ-020 The stall encodings, the ERET code 32'h0000000e and the FSM state encoding SHALL live in the shared CPU defines package.
REQ-021 The watchdog and stall_cnt logic SHALL be one sub-module, stall_wdt, with inputs stall_any, flush, wdt_clr and outputs stall_timeout, stall_cnt.

Verification
REQ-022 Scenario: stallreq_id = 1 and stallreq_mem = 1 together -> stall = 6'b011111; stallreq_id alone -> 6'b000111.
REQ-023 Scenario: excepttype_i = 32'h00000001 in IDLE -> flush = 1, new_pc = 32'hBFC00380, stall = 0; stallreq_if = 1 on the next 2 cycles -> stall = 0.
REQ-024 Scenario: excepttype_i = 32'h0000000e with cp0_epc_i = 32'h80001234 -> new_pc = 32'h80001234; a second exception on the following cycle -> flush = 0.
REQ-025 Scenario: stallreq_ex held for 1024 cycles with STALL_TIMEOUT = 1024 -> stall_timeout = 1 after the 1024th edge and stall_cnt = 1024; wdt_clr with stall released -> stall_timeout = 0.
REQ-026 Scenario: stall_cnt preloaded through hierarchy to 32'hFFFFFFFF, one stalled cycle -> stall_cnt = 0.
REQ-027 Scenario: rst = 0 during BLANK -> state = IDLE before the next edge; an exception arriving in the first cycle after release -> flush = 1.
